multiply_tiled_seq: RTL and testbench

MULTIPLY_TILED_SEQ -- requirements
Module: multiply_tiled_seq

---
 rtl/multiply_tiled_seq.sv | 138 +++++++++++++
 tb/tb_multiply_tiled_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_tiled_seq.sv
// Sequential unsigned multiplier built from NUM_MULTS parallel 26x17 tile multipliers.
// Each MUL cycle sums one group of shifted tile products into a full-width accumulator.
module multiply_tiled_seq #(
    parameter int A_W       = 51,
    parameter int B_W       = 51,
    parameter int NUM_MULTS = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   product,
    output logic                 busy
);

    localparam int NX    = (A_W + 25) / 26;
    localparam int NY    = (B_W + 16) / 17;
    localparam int T     = NX * NY;
    localparam int P     = (T + NUM_MULTS - 1) / NUM_MULTS;
    localparam int PW    = A_W + B_W;
    localparam int AX_W  = NX * 26;
    localparam int BX_W  = NY * 17;
    localparam int EXT_W = AX_W + BX_W;
    localparam int ACC_W = PW + 1;
    localparam int PC_W  = (P > 1) ? $clog2(P) : 1;

    if (A_W < 2 || A_W > 1024 || B_W < 2 || B_W > 1024 ||
        NUM_MULTS < 1 || NUM_MULTS > T) begin : g_param_check
        $error("multiply_tiled_seq: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             r_state;
    logic [A_W-1:0]     r_a;
    logic [B_W-1:0]     r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [PC_W-1:0]    r_pass;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [PW-1:0]      r_product;

    logic [AX_W-1:0]    w_a_ext;
    logic [BX_W-1:0]    w_b_ext;
    logic [EXT_W-1:0]   w_pass_sum;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_a_ext = AX_W'(r_a);
    assign w_b_ext = BX_W'(r_b);

    // One 26x17 tile product, placed at its weight 2^(26x+17y) within the extended width.
    function automatic logic [EXT_W-1:0] tile_term(input int t,
                                                   input logic [AX_W-1:0] ax,
                                                   input logic [BX_W-1:0] bx);
        int          x;
        int          y;
        logic [25:0] va;
        logic [16:0] vb;
        logic [42:0] pp;
        x  = t % NX;
        y  = t / NX;
        va = ax[26*x +: 26];
        vb = bx[17*y +: 17];
        pp = {17'd0, va} * {26'd0, vb};
        return EXT_W'(pp) << (26*x + 17*y);
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_pass_sum = '0;
        for (int m = 0; m < NUM_MULTS; m++) begin
            if (int'(r_pass) * NUM_MULTS + m < T)
                w_pass_sum = w_pass_sum
                           + tile_term(int'(r_pass) * NUM_MULTS + m, w_a_ext, w_b_ext);
        end
    end

    // The true product is below 2^PW, so dropping the upper extension bits loses nothing.
    assign w_acc_next = r_acc + ACC_W'(w_pass_sum);

    // NOTE: sequential state uses non-blocking assignments only; the operand registers
    // are left out of reset because they are always loaded before being used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_pass      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_acc      <= '0;
                        r_pass     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    if (r_pass == PC_W'(P - 1)) begin
                        r_product   <= w_acc_next[PW-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_pass <= r_pass + PC_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule

// File: tb/tb_multiply_tiled_seq.sv
// Directed bench for multiply_tiled_seq: three configurations (default, NUM_MULTS=1,
// 30x20 with NUM_MULTS=3) share one clock, reset and operand bus.
module tb_multiply_tiled_seq;

    logic         clk;
    logic         rst_n;
    logic [50:0]  a;
    logic [50:0]  b;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    wire  [2:0]   in_ready;
    wire  [2:0]   out_valid;
    wire  [2:0]   busy;
    wire  [101:0] prod0;
    wire  [101:0] prod1;
    wire  [49:0]  prod2;

    int n_tests = 0;
    int n_fail  = 0;

    multiply_tiled_seq u_dut0 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .product(prod0), .busy(busy[0])
    );

    multiply_tiled_seq #(.NUM_MULTS(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .product(prod1), .busy(busy[1])
    );

    multiply_tiled_seq #(.A_W(30), .B_W(20), .NUM_MULTS(3)) u_dut2 (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[29:0]), .b(b[19:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .product(prod2), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [101:0] get_prod(input int u);
        case (u)
            0:       return prod0;
            1:       return prod1;
            default: return {52'd0, prod2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [101:0] got, input logic [101:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; accepts on the next posedge, returns just after a
    // negedge with the DUT back in IDLE. lat counts negedges from acceptance to out_valid.
    task automatic do_op(input int u, input logic [50:0] av, input logic [50:0] bv,
                         output logic [101:0] pr, output int lat, output int bsy);
        a = av;
        b = bv;
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1 in_valid[u] = 1'b0;
        lat = 0;
        bsy = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy[u]) bsy++;
            if (out_valid[u]) break;
        end
        pr = get_prod(u);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1 out_ready[u] = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [50:0]  ONES51 = 51'h7FFFFFFFFFFFF;
    localparam logic [101:0] SQ51   = 102'h3FFFFFFFFFFFF0000000000001;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [101:0] pr;
        logic [101:0] held;
        logic [101:0] exp;
        logic [63:0]  r64;
        logic [50:0]  av;
        logic [50:0]  bv;
        int           lat;
        int           bsy;
        int           errs;

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = '0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  102'(in_ready),  102'h7);
        check("rst_out_valid", 102'(out_valid), 102'h0);
        check("rst_busy",      102'(busy),      102'h0);
        check("rst_prod0",     prod0,           102'h0);
        check("rst_prod1",     prod1,           102'h0);
        check("rst_prod2",     102'(prod2),     102'h0);
        rst_n = 1'b1;

        // First acceptance on the first edge after reset release; all-ones squared, P=1.
        do_op(0, ONES51, ONES51, pr, lat, bsy);
        check("d0_ones_prod", pr, SQ51);
        check("d0_ones_lat", 102'(lat), 102'd2);
        check("d0_ones_busy", 102'(bsy), 102'd2);
        check("d0_idle_after", 102'({out_valid[0], busy[0], in_ready[0]}), 102'b001);

        do_op(0, 51'd0, ONES51, pr, lat, bsy);
        check("d0_zero", pr, 102'd0);
        do_op(0, 51'd3, 51'd5, pr, lat, bsy);
        check("d0_3x5", pr, 102'd15);
        do_op(0, 51'h4000000, 51'h20000, pr, lat, bsy);
        check("d0_tile_edge", pr, 102'h80000000000);
        do_op(0, 51'h4000000000000, 51'h4000000000000, pr, lat, bsy);
        check("d0_msb", pr, 102'h10000000000000000000000000);
        do_op(0, 51'h3FFFFFF, 51'h1FFFF, pr, lat, bsy);
        check("d0_single_tile", pr, 102'h7FFFBFE0001);

        // out_ready while idle is ignored.
        out_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b0;
        check("d0_idle_ready", 102'({out_valid[0], busy[0]}), 102'd0);
        check("d0_idle_hold", prod0, 102'h7FFFBFE0001);

        // NUM_MULTS=1: six passes.
        do_op(1, 51'd3, 51'd5, pr, lat, bsy);
        check("d1_3x5", pr, 102'd15);
        check("d1_lat", 102'(lat), 102'd7);
        check("d1_busy", 102'(bsy), 102'd7);
        do_op(1, ONES51, ONES51, pr, lat, bsy);
        check("d1_ones", pr, SQ51);
        check("d1_ones_lat", 102'(lat), 102'd7);

        // 30x20 operands, NUM_MULTS=3: two passes; (2^30-1)*(2^20-1) = 2^50-2^30-2^20+1.
        do_op(2, 51'h3FFFFFFF, 51'hFFFFF, pr, lat, bsy);
        check("d2_ones", pr, 102'h3FFFFBFF00001);
        check("d2_lat", 102'(lat), 102'd3);
        do_op(2, 51'h2000001, 51'h10001, pr, lat, bsy);
        check("d2_sparse", pr, 102'h20002010001);

        // Backpressure: product held for 10 cycles while in_valid is ignored.
        a = 51'd1000;
        b = 51'd1000;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        lat = 0;
        while (lat < 40 && !out_valid[0]) begin
            @(negedge clk);
            lat++;
        end
        held = prod0;
        check("bp_prod", held, 102'd1000000);
        a = 51'd7;
        b = 51'd9;
        in_valid[0] = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (prod0 !== held || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) errs++;
        end
        check("bp_stable", 102'(errs), 102'd0);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_release", 102'({out_valid[0], busy[0], in_ready[0]}), 102'b001);
        check("bp_no_side_effect", prod0, 102'd1000000);
        do_op(0, 51'd7, 51'd9, pr, lat, bsy);
        check("bp_next", pr, 102'd63);

        // Reset during pass 3 of a NUM_MULTS=1 operation aborts it.
        a = 51'd3;
        b = 51'd5;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 102'(busy[1]), 102'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", 102'({out_valid[1], busy[1], in_ready[1]}), 102'b001);
        check("abort_prod", prod1, 102'd0);
        rst_n = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[1] !== 1'b0) errs++;
        end
        check("abort_no_valid", 102'(errs), 102'd0);
        do_op(1, 51'd2, 51'd2, pr, lat, bsy);
        check("abort_next", pr, 102'd4);
        check("abort_next_lat", 102'(lat), 102'd7);

        // Pseudo-random operands against a reference product.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 6; i++) begin
                r64 = {$urandom, $urandom};
                av  = r64[50:0];
                r64 = {$urandom, $urandom};
                bv  = r64[50:0];
                if (u == 2) begin
                    av = {21'd0, av[29:0]};
                    bv = {31'd0, bv[19:0]};
                end
                exp = {51'd0, av} * {51'd0, bv};
                do_op(u, av, bv, pr, lat, bsy);
                check($sformatf("rand_u%0d_%0d", u, i), pr, exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
